// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU mode encodings and the multiply sequencer state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SRA = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_mul_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module   : alu_mul_seq
// Brief    : Shift-and-add RV32M MUL sequencer driving the shared core ALU.
//            Optional macro ALU_MUL_EARLY_EXIT_EN ends BUSY once the
//            remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            alu_req,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_mode,
    input  logic [XLEN-1:0] alu_q
);

    alu_mul_state_t  r_state;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [4:0]      r_cnt;
    logic            r_start_ready;
    logic            r_result_valid;
    logic            r_alu_req;

    logic [XLEN-1:0] w_acc_step;
    logic            w_last;
    logic            w_skip;

    // The ALU is combinational on alu_a/alu_b, so alu_q is acc + mcand now.
    assign w_acc_step = r_mplier[0] ? alu_q : r_acc;
    assign w_last     = (r_cnt == 5'd31);

`ifdef ALU_MUL_EARLY_EXIT_EN
    assign w_skip = (r_mplier == '0);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_cnt          <= '0;
            r_start_ready  <= 1'b1;
            r_result_valid <= 1'b0;
            r_alu_req      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_acc         <= '0;
                        r_mcand       <= op_a;
                        r_mplier      <= op_b;
                        r_cnt         <= '0;
                        r_state       <= BUSY;
                        r_start_ready <= 1'b0;
                        r_alu_req     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_skip) begin
                        r_state        <= DONE;
                        r_alu_req      <= 1'b0;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_acc    <= w_acc_step;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 5'd1;
                        if (w_last) begin
                            r_state        <= DONE;
                            r_alu_req      <= 1'b0;
                            r_result_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        r_state        <= IDLE;
                        r_result_valid <= 1'b0;
                        r_start_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_start_ready  <= 1'b1;
                    r_result_valid <= 1'b0;
                    r_alu_req      <= 1'b0;
                end
            endcase
        end
    end

    // Operands are forced to zero whenever the ALU belongs to the core.
    assign start_ready  = r_start_ready;
    assign result_valid = r_result_valid;
    assign result       = r_result_valid ? r_acc : '0;
    assign alu_req      = r_alu_req;
    assign alu_a        = r_alu_req ? r_acc   : '0;
    assign alu_b        = r_alu_req ? r_mcand : '0;
    assign alu_mode     = ALU_ADD;

endmodule

`default_nettype wire
